tournament_chooser: RTL and testbench

TOURNAMENT_CHOOSER -- requirements
Module: tournament_chooser

---
 rtl/tournament_chooser_pkg.sv | 36 +++
 rtl/pred_track_fifo.sv | 69 ++++++
 rtl/tournament_chooser.sv | 103 ++++++++++
 tb/tb_tournament_chooser.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tournament_chooser_pkg.sv
// Shared defaults, FIFO entry layout and choice-counter constants for the
// tournament chooser.
package tournament_chooser_pkg;

    localparam int GHR_W_DEF = 12;
    localparam int DEPTH_DEF = 4;

    // Two-bit choice counter: 0..1 favour local, 2..3 favour global.
    localparam logic [1:0] CT_MIN        = 2'd0;
    localparam logic [1:0] CT_RESET      = 2'd1;
    localparam logic [1:0] CT_SEL_GLOBAL = 2'd2;
    localparam logic [1:0] CT_MAX        = 2'd3;

    // Pending-prediction record at the default history width. The top
    // re-declares the same layout at its own GHR_W and hands it to the FIFO.
    typedef struct packed {
        logic                 local_pred;
        logic                 global_pred;
        logic [GHR_W_DEF-1:0] ghr;
    } pend_entry_t;

    // Train the chooser towards whichever component alone was right.
    function automatic logic [1:0] ct_train(input logic [1:0] ct,
                                            input logic       local_ok,
                                            input logic       global_ok);
        logic [1:0] nxt;
        nxt = ct;
        if (local_ok && !global_ok && (ct != CT_MIN)) begin
            nxt = ct - 2'd1;
        end else if (global_ok && !local_ok && (ct != CT_MAX)) begin
            nxt = ct + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pred_track_fifo.sv
// Small FIFO of in-flight predictions; pops are always the oldest entry.
// Push while full is only honoured together with a pop.
module pred_track_fifo
    import tournament_chooser_pkg::*;
#(
    parameter int  DEPTH   = DEPTH_DEF,
    parameter type entry_t = pend_entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               push_ok, pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    // Pointer and occupancy next-state; pointers wrap since DEPTH is 2^n.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament chooser: a history-indexed table of 2-bit counters picks the
// local or global prediction; outcomes train it once the branch resolves.
module tournament_chooser
    import tournament_chooser_pkg::*;
#(
    parameter int GHR_W = GHR_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   pred_valid,
    input  logic                   local_pred,
    input  logic                   global_pred,
    input  logic                   resolve_valid,
    input  logic                   resolve_taken,
    output logic                   out_valid,
    output logic                   pred_taken,
    output logic                   pred_src,
    output logic                   full,
    output logic [$clog2(DEPTH):0] pend_count,
    output logic                   err_underflow
);

    localparam int CT_N = 2 ** GHR_W;

    typedef struct packed {
        logic             local_pred;
        logic             global_pred;
        logic [GHR_W-1:0] ghr;
    } track_entry_t;

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [1:0]       ct_q [CT_N];
    logic             out_valid_q, pred_taken_q, pred_src_q, err_underflow_q;

    track_entry_t     push_entry, pop_entry;
    logic             fifo_empty, accept, pop, sel_global;
    logic [1:0]       ct_upd;

    assign accept     = pred_valid && (!full || resolve_valid);
    assign pop        = resolve_valid && !fifo_empty;
    assign sel_global = (ct_q[ghr_q] >= CT_SEL_GLOBAL);
    assign push_entry = '{local_pred: local_pred, global_pred: global_pred, ghr: ghr_q};
    assign ct_upd     = ct_train(ct_q[pop_entry.ghr],
                                 pop_entry.local_pred  == resolve_taken,
                                 pop_entry.global_pred == resolve_taken);
    assign ghr_d      = pop ? {ghr_q[GHR_W-2:0], resolve_taken} : ghr_q;

    pred_track_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (track_entry_t)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (pop_entry),
        .full      (full),
        .empty     (fifo_empty),
        .count     (pend_count)
    );

    // Registered prediction; the request sees CT and GHR before any
    // same-cycle resolve updates them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_src_q   <= 1'b0;
        end else begin
            out_valid_q  <= accept;
            pred_src_q   <= accept && sel_global;
            pred_taken_q <= accept && (sel_global ? global_pred : local_pred);
        end
    end

    // Global history shifts only on a real pop; underflow flag is sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ghr_q           <= '0;
            err_underflow_q <= 1'b0;
        end else begin
            ghr_q           <= ghr_d;
            err_underflow_q <= err_underflow_q || (resolve_valid && fifo_empty);
        end
    end

    // Choice table trained at the history the popped branch was predicted with.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CT_N; i++) ct_q[i] <= CT_RESET;
        end else if (pop) begin
            ct_q[pop_entry.ghr] <= ct_upd;
        end
    end

    assign out_valid     = out_valid_q;
    assign pred_taken    = pred_taken_q;
    assign pred_src      = pred_src_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_tournament_chooser.sv
// Directed bench for tournament_chooser with a queue-based reference model.
module tb_tournament_chooser;

    localparam int GHR_W = 12;
    localparam int DEPTH = 4;
    localparam int CT_N  = 1 << GHR_W;
    localparam int MASK  = CT_N - 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pred_valid = 1'b0, local_pred = 1'b0, global_pred = 1'b0;
    logic       resolve_valid = 1'b0, resolve_taken = 1'b0;
    logic       out_valid, pred_taken, pred_src, full, err_underflow;
    logic [$clog2(DEPTH):0] pend_count;

    tournament_chooser #(.GHR_W(GHR_W), .DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .pred_valid    (pred_valid),
        .local_pred    (local_pred),
        .global_pred   (global_pred),
        .resolve_valid (resolve_valid),
        .resolve_taken (resolve_taken),
        .out_valid     (out_valid),
        .pred_taken    (pred_taken),
        .pred_src      (pred_src),
        .full          (full),
        .pend_count    (pend_count),
        .err_underflow (err_underflow)
    );

    always #5 clock = ~clock;

    // Reference model state
    typedef struct { bit l; bit g; int h; } ent_t;
    ent_t q[$];
    int   ct_m [CT_N];
    int   ghr_m = 0;
    bit   err_m = 0;
    bit   exp_valid = 0, exp_taken = 0, exp_src = 0;

    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ghr_m = 0;
        err_m = 0;
        exp_valid = 0;
        exp_taken = 0;
        exp_src = 0;
        for (int i = 0; i < CT_N; i++) ct_m[i] = 1;
    endtask

    initial model_reset();

    // Model: evaluate each clock edge from the spec rules.
    initial forever begin
        @(posedge clock or posedge reset);
        if (reset) begin
            model_reset();
        end else begin
            bit acc, do_pop, src;
            ent_t e;
            acc    = pred_valid && ((q.size() < DEPTH) || resolve_valid);
            do_pop = resolve_valid && (q.size() > 0);
            exp_valid = acc;
            if (acc) begin
                src       = (ct_m[ghr_m] >= 2);
                exp_src   = src;
                exp_taken = src ? global_pred : local_pred;
            end
            if (resolve_valid && q.size() == 0) err_m = 1;
            e = '{l: local_pred, g: global_pred, h: ghr_m};
            if (do_pop) begin
                ent_t o;
                bit lc, gc;
                o  = q.pop_front();
                lc = (o.l == resolve_taken);
                gc = (o.g == resolve_taken);
                if (lc && !gc && ct_m[o.h] > 0) ct_m[o.h] = ct_m[o.h] - 1;
                if (gc && !lc && ct_m[o.h] < 3) ct_m[o.h] = ct_m[o.h] + 1;
                ghr_m = ((ghr_m << 1) | int'(resolve_taken)) & MASK;
            end
            if (acc) q.push_back(e);
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    initial forever begin
        @(negedge clock);
        chk("out_valid", out_valid, exp_valid);
        if (exp_valid) begin
            chk("pred_taken", pred_taken, exp_taken);
            chk("pred_src", pred_src, exp_src);
        end
        chk("pend_count", pend_count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("err_underflow", err_underflow, err_m);
        chk("ghr", dut.ghr_q, ghr_m);
    end

    task automatic step(input bit pv, input bit lp, input bit gp, input bit rv, input bit rt);
        pred_valid    = pv;
        local_pred    = lp;
        global_pred   = gp;
        resolve_valid = rv;
        resolve_taken = rt;
        @(negedge clock);
        pred_valid    = 0;
        resolve_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clock);
        reset = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got 0 expected 1");
        $fatal(1, "bench timeout");
    end

    initial begin
        int saved_ghr;
        repeat (2) @(negedge clock);
        reset = 0;
        chk("reset pend_count", pend_count, 0);
        chk("reset out_valid", out_valid, 0);

        // First request after reset: CT=1 so local wins
        step(1, 1, 0, 0, 0);
        chk("first out_valid", out_valid, 1);
        chk("first pred_taken", pred_taken, 1);
        chk("first pred_src", pred_src, 0);
        chk("first pend_count", pend_count, 1);

        // Global-right rounds, shifting ones into the history
        do_reset();
        repeat (3) begin
            step(1, 0, 1, 0, 0);
            step(0, 0, 0, 1, 1);
        end
        chk("ct0 after 3 rounds", dut.ct_q[0], 2);
        chk("model ct0 after 3 rounds", ct_m[0], 2);
        chk("ghr after 3 ones", dut.ghr_q, 7);

        // Rounds that stay at GHR=0 and saturate CT[0]
        do_reset();
        repeat (3) begin
            step(1, 1, 0, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("ct0 saturated", dut.ct_q[0], 3);
        step(1, 1, 0, 0, 0);
        chk("global chosen src", pred_src, 1);
        chk("global chosen taken", pred_taken, 0);
        step(0, 0, 0, 1, 0);
        repeat (4) begin
            step(1, 0, 1, 0, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("ct0 floor", dut.ct_q[0], 0);

        // Fill, drop when full, accept with simultaneous resolve
        do_reset();
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("full after 4", full, 1);
        chk("pend 4", pend_count, 4);
        step(1, 0, 1, 0, 0);
        chk("dropped out_valid", out_valid, 0);
        chk("dropped pend", pend_count, 4);
        step(1, 1, 0, 1, 1);
        chk("push+pop out_valid", out_valid, 1);
        chk("push+pop pend", pend_count, 4);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(1, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("drained", pend_count, 0);

        // Underflow
        saved_ghr = ghr_m;
        step(0, 0, 0, 1, 1);
        chk("underflow flag", err_underflow, 1);
        chk("underflow pend", pend_count, 0);
        chk("underflow ghr", dut.ghr_q, saved_ghr);
        step(0, 0, 0, 0, 0);
        chk("underflow sticky", err_underflow, 1);

        // History pattern 1,0,1 then async reset with entries pending
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        chk("ghr 101", dut.ghr_q, 12'h005);
        step(1, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("pend before reset", pend_count, 2);
        #2 reset = 1;
        #1;
        chk("async pend", pend_count, 0);
        chk("async ghr", dut.ghr_q, 0);
        chk("async out_valid", out_valid, 0);
        @(negedge clock);
        reset = 0;
        step(1, 1, 0, 0, 0);
        chk("post-reset src", pred_src, 0);
        chk("post-reset taken", pred_taken, 1);
        step(0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
